// File: rtl/wb_spi_mem_if.sv
// wb_spi_mem_if: Wishbone classic request/response bundle between the core's master and wb_spi_mem.
interface wb_spi_mem_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_spi_mem.sv
// wb_spi_mem: Wishbone slave turning each strobe into one SPI mode-0 READ/WRITE burst to PSRAM/flash.
// Define SPI_FAST_READ_EN to issue FAST READ (0x0B) with 8 dummy clocks instead of READ (0x03).
module wb_spi_mem #(
   parameter int CLK_DIV   = 2,
   parameter int ADDR_BITS = 24
) (
   input  logic        clk,
   input  logic        reset,
   wb_spi_mem_if.slave wb,
   output logic        spi_sck,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);
`ifdef SPI_FAST_READ_EN
   localparam logic [7:0] RD_CMD   = 8'h0B;
   localparam int         RD_DUMMY = 8;
`else
   localparam logic [7:0] RD_CMD   = 8'h03;
   localparam int         RD_DUMMY = 0;
`endif
   localparam int FW = 8 + ADDR_BITS + 40;
   localparam int CW = $clog2(FW) + 1;
   localparam int PW = $clog2(2 * CLK_DIV) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n, nbits;
   logic [PW-1:0]   ph, ph_n;
   logic [FW-1:0]   sh, sh_n, frame;
   logic [31:0]     rx, rx_n, wdata, dat_q, dat_n;
   logic [1:0]      lane;
   logic [2:0]      nbytes;
   logic            rd, rd_n, sck_n, cs_n_n, mosi_n, ack_q, ack_n;
   logic            unused;

   assign unused = ^{wb.wb_adr_i[31:ADDR_BITS], wb.wb_adr_i[1:0]};

   // Write payload is left-aligned, lowest lane first so the memory sees ascending bytes.
   always_comb begin
      lane   = 2'd0;
      nbytes = 3'd0;
      wdata  = '0;
      frame  = '0;
      nbits  = '0;
      case (wb.wb_sel_i)
         4'b0001: begin lane = 2'd0; nbytes = 3'd1; wdata = {wb.wb_dat_i[7:0], 24'h0}; end
         4'b0010: begin lane = 2'd1; nbytes = 3'd1; wdata = {wb.wb_dat_i[15:8], 24'h0}; end
         4'b0100: begin lane = 2'd2; nbytes = 3'd1; wdata = {wb.wb_dat_i[23:16], 24'h0}; end
         4'b1000: begin lane = 2'd3; nbytes = 3'd1; wdata = {wb.wb_dat_i[31:24], 24'h0}; end
         4'b0011: begin lane = 2'd0; nbytes = 3'd2; wdata = {wb.wb_dat_i[7:0], wb.wb_dat_i[15:8], 16'h0}; end
         4'b1100: begin lane = 2'd2; nbytes = 3'd2; wdata = {wb.wb_dat_i[23:16], wb.wb_dat_i[31:24], 16'h0}; end
         4'b1111: begin
            lane = 2'd0; nbytes = 3'd4;
            wdata = {wb.wb_dat_i[7:0], wb.wb_dat_i[15:8], wb.wb_dat_i[23:16], wb.wb_dat_i[31:24]};
         end
         default: nbytes = 3'd0;
      endcase
      if (wb.wb_we_i) begin
         frame = {8'h02, wb.wb_adr_i[ADDR_BITS-1:2], lane, wdata, 8'h00};
         nbits = (nbytes == 3'd0) ? '0 : CW'(8 + ADDR_BITS + 8 * int'(nbytes));
      end else begin
         frame = {RD_CMD, wb.wb_adr_i[ADDR_BITS-1:2], 2'b00, 40'h0};
         nbits = CW'(8 + ADDR_BITS + RD_DUMMY + 32);
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ph_n    = ph;
      sh_n    = sh;
      rx_n    = rx;
      rd_n    = rd;
      sck_n   = spi_sck;
      cs_n_n  = spi_cs_n;
      mosi_n  = spi_mosi;
      ack_n   = 1'b0;
      dat_n   = dat_q;
      case (state)
         IDLE: if (wb.wb_cyc_i && wb.wb_stb_i) begin
            state_n = SHIFT;
            rd_n    = !wb.wb_we_i;
            cnt_n   = nbits;
            ph_n    = '0;
            // An illegal write keeps CS high and falls straight through to DONE.
            if (nbits != '0) begin
               cs_n_n = 1'b0;
               mosi_n = frame[FW-1];
               sh_n   = {frame[FW-2:0], 1'b0};
            end
         end
         SHIFT: if (cnt == '0) begin
            state_n = DONE;
            ack_n   = 1'b1;
         end else begin
            ph_n = ph + 1'b1;
            if (ph == PW'(CLK_DIV - 1)) sck_n = 1'b1;
            if (ph == PW'(CLK_DIV) && cnt <= CW'(32)) rx_n = {rx[30:0], spi_miso};
            if (ph == PW'(2 * CLK_DIV - 1)) begin
               ph_n  = '0;
               sck_n = 1'b0;
               cnt_n = cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state_n = DONE;
                  ack_n   = 1'b1;
                  cs_n_n  = 1'b1;
                  mosi_n  = 1'b0;
                  if (rd) dat_n = {rx_n[7:0], rx_n[15:8], rx_n[23:16], rx_n[31:24]};
               end else begin
                  mosi_n = sh[FW-1];
                  sh_n   = {sh[FW-2:0], 1'b0};
               end
            end
         end
         DONE: begin
            state_n = GAP;
            ph_n    = '0;
         end
         GAP: begin
            ph_n = ph + 1'b1;
            if (ph == PW'(CLK_DIV - 1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         ph       <= '0;
         sh       <= '0;
         rx       <= '0;
         rd       <= 1'b0;
         spi_sck  <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_mosi <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         ph       <= ph_n;
         sh       <= sh_n;
         rx       <= rx_n;
         rd       <= rd_n;
         spi_sck  <= sck_n;
         spi_cs_n <= cs_n_n;
         spi_mosi <= mosi_n;
         ack_q    <= ack_n;
         dat_q    <= dat_n;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
endmodule

// File: tb/tb_wb_spi_mem.sv
// tb_wb_spi_mem: directed checks of wb_spi_mem against a behavioural SPI memory (honours SPI_FAST_READ_EN).
`timescale 1ns/1ps
module tb_wb_spi_mem;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic spi_sck, spi_cs_n, spi_mosi;
   logic spi_miso = 1'b0;

   wb_spi_mem_if wb();

   wb_spi_mem dut (
      .clk(clk), .reset(reset), .wb(wb.slave),
      .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

`ifdef SPI_FAST_READ_EN
   localparam int DS = 40;
   localparam int RD_LAT = 289;
   localparam int RD_LEN = 9;
   localparam logic [79:0] RF0 = 80'h0B000004_00_00000000;
   localparam logic [79:0] RF1 = 80'h0B000010_00_00000000;
`else
   localparam int DS = 32;
   localparam int RD_LAT = 257;
   localparam int RD_LEN = 8;
   localparam logic [79:0] RF0 = 80'h03000004_00000000;
   localparam logic [79:0] RF1 = 80'h03000010_00000000;
`endif

   int errors = 0, checks = 0;
   int ack_cnt = 0, cs_falls = 0, sck_rises = 0;

   // SPI memory model: 256 bytes, low address byte only.
   logic [7:0]  mem [0:255];
   logic [7:0]  cur, ma, wa;
   int          bitn;
   logic [7:0]  rxb [$];
   logic [79:0] lf;
   int          lf_len;

   always @(posedge clk) if (wb.wb_ack_o === 1'b1) ack_cnt++;

   always @(negedge spi_cs_n) begin
      cs_falls++;
      bitn = 0;
      rxb.delete();
   end

   always @(posedge spi_sck) begin
      sck_rises++;
      if (spi_cs_n === 1'b0) begin
         cur = {cur[6:0], spi_mosi};
         bitn++;
         if (bitn % 8 == 0) rxb.push_back(cur);
      end
   end

   always @(negedge spi_sck) begin
      spi_miso = 1'b0;
      if (spi_cs_n === 1'b0 && rxb.size() >= 4 && rxb[0] != 8'h02 && bitn >= DS && bitn < DS + 32) begin
         ma = rxb[3] + 8'((bitn - DS) / 8);
         spi_miso = mem[ma][7 - ((bitn - DS) % 8)];
      end
   end

   always @(posedge spi_cs_n) begin
      lf = '0;
      lf_len = rxb.size();
      foreach (rxb[i]) lf = {lf[71:0], rxb[i]};
      if (rxb.size() > 4 && rxb[0] == 8'h02)
         for (int i = 4; i < rxb.size(); i++) begin
            wa = rxb[3] + 8'(i - 4);
            mem[wa] = rxb[i];
         end
   end

   task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      @(negedge clk);
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
      wb.wb_sel_i = sel; wb.wb_adr_i = adr; wb.wb_dat_i = dat;
      @(posedge clk);
   endtask

   // Samples each following negedge (cycle T+j); drops the strobe after the acceptance cycle.
   task automatic wait_ack(input int j0, output int lat, output int csl, output logic [31:0] d);
      lat = -1; csl = 0; d = '0;
      for (int j = j0 + 1; j <= j0 + 1000 && lat < 0; j++) begin
         @(negedge clk);
         if (j == 1) begin wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; end
         if (spi_cs_n === 1'b0) csl++;
         if (wb.wb_ack_o === 1'b1) begin lat = j; d = wb.wb_dat_o; end
      end
   endtask

   task automatic test_reset();
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
      wb.wb_sel_i = 4'hF; wb.wb_adr_i = '0; wb.wb_dat_i = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
      checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
      checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
      checks++; if (wb.wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", wb.wb_ack_o); end
      checks++; if (wb.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", wb.wb_dat_o); end
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_write_sizes();
      logic [3:0]  sel [3]  = '{4'hF, 4'h8, 4'hC};
      logic [31:0] adr [3]  = '{32'h80000010, 32'h80000013, 32'h00000010};
      logic [31:0] dat [3]  = '{32'h11223344, 32'hAB000000, 32'h55660000};
      int          elat [3] = '{257, 161, 193};
      int          elen [3] = '{8, 5, 6};
      logic [79:0] efr [3]  = '{80'h02000010_44332211, 80'h02000013_AB, 80'h02000012_6655};
      int lat, csl;
      logic [31:0] d;
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, sel[i], adr[i], dat[i]);
         wait_ack(0, lat, csl, d);
         checks++; if (lat != elat[i]) begin errors++; $display("FAIL wr%0d_latency: got %0d want %0d", i, lat, elat[i]); end
         checks++; if (csl != elat[i] - 1) begin errors++; $display("FAIL wr%0d_cs_low: got %0d want %0d", i, csl, elat[i] - 1); end
         @(negedge clk);
         checks++; if (wb.wb_ack_o !== 1'b0) begin errors++; $display("FAIL wr%0d_ack_width: got %b want 0", i, wb.wb_ack_o); end
         checks++; if (lf_len != elen[i] || lf !== efr[i]) begin
            errors++; $display("FAIL wr%0d_frame: got %0d bytes %h want %0d bytes %h", i, lf_len, lf, elen[i], efr[i]);
         end
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic test_read();
      logic [31:0] adr [2] = '{32'h40000006, 32'h00000010};
      logic [31:0] edat [2] = '{32'h12345678, 32'h55663344};
      logic [79:0] efr [2] = '{RF0, RF1};
      int lat, csl;
      logic [31:0] d;
      for (int i = 0; i < 2; i++) begin
         issue(1'b0, 4'h0, adr[i], 32'hDEADBEEF);
         wait_ack(0, lat, csl, d);
         checks++; if (lat != RD_LAT) begin errors++; $display("FAIL rd%0d_latency: got %0d want %0d", i, lat, RD_LAT); end
         checks++; if (d !== edat[i]) begin errors++; $display("FAIL rd%0d_data: got %h want %h", i, d, edat[i]); end
         checks++; if (csl != RD_LAT - 1) begin errors++; $display("FAIL rd%0d_cs_low: got %0d want %0d", i, csl, RD_LAT - 1); end
         checks++; if (lf_len != RD_LEN || lf !== efr[i]) begin
            errors++; $display("FAIL rd%0d_frame: got %0d bytes %h want %0d bytes %h", i, lf_len, lf, RD_LEN, efr[i]);
         end
         repeat (4) @(negedge clk);
         checks++; if (wb.wb_dat_o !== edat[i]) begin errors++; $display("FAIL rd%0d_dat_hold: got %h want %h", i, wb.wb_dat_o, edat[i]); end
      end
   endtask

   task automatic test_illegal_sel();
      int c0, s0, lat, csl;
      logic [31:0] d;
      c0 = cs_falls; s0 = sck_rises;
      issue(1'b1, 4'b0101, 32'h00000004, 32'hFFFFFFFF);
      wait_ack(0, lat, csl, d);
      checks++; if (lat != 2) begin errors++; $display("FAIL illegal_latency: got %0d want 2", lat); end
      checks++; if (cs_falls - c0 != 0 || csl != 0) begin errors++; $display("FAIL illegal_cs: got %0d falls want 0", cs_falls - c0); end
      checks++; if (sck_rises - s0 != 0) begin errors++; $display("FAIL illegal_sck: got %0d edges want 0", sck_rises - s0); end
      repeat (4) @(negedge clk);
      issue(1'b0, 4'hF, 32'h00000004, 32'h0);
      wait_ack(0, lat, csl, d);
      checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL illegal_mem_unchanged: got %h want 12345678", d); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int c0, a0, lat, csl, hi;
      logic [31:0] d;
      c0 = cs_falls; a0 = ack_cnt; lat = -1;
      issue(1'b1, 4'hF, 32'h00000020, 32'hCAFEF00D);
      for (int j = 1; j <= 1000 && lat < 0; j++) begin
         @(negedge clk);
         if (j == 1 || j == 51) begin wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; end
         if (j == 50) begin
            wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = 32'h00000030;
         end
         if (wb.wb_ack_o === 1'b1) lat = j;
      end
      checks++; if (lat != 257) begin errors++; $display("FAIL b2b_latency: got %0d want 257", lat); end
      hi = (spi_cs_n === 1'b1) ? 1 : 0;
      @(negedge clk);
      checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL b2b_ack_count: got %0d want 1", ack_cnt - a0); end
      // Hold a read request from the cycle after ack until the bridge takes it.
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF; wb.wb_adr_i = 32'h00000020;
      for (int k = 0; k < 20 && spi_cs_n === 1'b1; k++) begin
         hi++;
         @(negedge clk);
      end
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
      checks++; if (hi != 4) begin errors++; $display("FAIL b2b_cs_gap: got %0d cycles want 4", hi); end
      wait_ack(1, lat, csl, d);
      checks++; if (lat != RD_LAT) begin errors++; $display("FAIL b2b_rd_latency: got %0d want %0d", lat, RD_LAT); end
      checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rd_data: got %h want cafef00d", d); end
      checks++; if (cs_falls - c0 != 2) begin errors++; $display("FAIL b2b_bursts: got %0d want 2", cs_falls - c0); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      int a0, lat, csl;
      logic [31:0] d;
      issue(1'b0, 4'hF, 32'h00000004, 32'h0);
      for (int j = 1; j <= 100; j++) begin
         @(negedge clk);
         if (j == 1) begin wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; end
      end
      a0 = ack_cnt;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL mid_reset_cs_n: got %b want 1", spi_cs_n); end
      checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL mid_reset_sck: got %b want 0", spi_sck); end
      checks++; if (int'(dut.state) != 0) begin errors++; $display("FAIL mid_reset_state: got %0d want 0", int'(dut.state)); end
      checks++; if (wb.wb_dat_o !== 32'h0) begin errors++; $display("FAIL mid_reset_dat: got %h want 0", wb.wb_dat_o); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (300) @(negedge clk);
      checks++; if (ack_cnt != a0) begin errors++; $display("FAIL mid_reset_no_ack: got %0d acks want 0", ack_cnt - a0); end
      issue(1'b0, 4'hF, 32'h00000004, 32'h0);
      wait_ack(0, lat, csl, d);
      checks++; if (lat != RD_LAT) begin errors++; $display("FAIL post_reset_latency: got %0d want %0d", lat, RD_LAT); end
      checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL post_reset_data: got %h want 12345678", d); end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[4] = 8'h78; mem[5] = 8'h56; mem[6] = 8'h34; mem[7] = 8'h12;
      test_reset();
      test_write_sizes();
      test_read();
      test_illegal_sel();
      test_back_to_back();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
